spi_tx_arbiter: RTL and testbench
=================================

SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, meaning CLK_1KHZ cycles allowed in WAIT before abort (legal range 2..255).
REQ-002 CLK_1KHZ  input  1  system clock; all state changes on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 REQ  input  3  per-requester transfer request; bit i belongs to requester i.
REQ-005 DATA0, DATA1, DATA2  input  8 each  byte offered by requester i; held stable while REQ[i] is high.
REQ-006 ACK  output  3  one-cycle pulse on bit i when requester i's byte is taken.
REQ-007 SPI_BUSY  input  1  SPI master busy flag.
REQ-008 SPI_DONE  input  1  SPI master one-cycle end-of-byte pulse.
REQ-009 DATA  output  8  byte presented to the SPI master.
REQ-010 START  output  1  one-cycle launch pulse to the SPI master.
REQ-011 GRANT_ID  output  2  index of the requester currently owning the SPI master (0..2).
REQ-012 TX_OK  output  1  one-cycle pulse on successful completion.
REQ-013 TX_ERR  output  1  one-cycle pulse on timeout abort.

Function
REQ-014 States SHALL be IDLE and WAIT only.
REQ-015 IDLE -> WAIT SHALL occur on the first edge where REQ != 0 and SPI_BUSY = 0.
- On that edge: DATA <= DATA[sel]; GRANT_ID <= sel; START <= 1; ACK[sel] <= 1; timer <= 0.
REQ-016 Latency SHALL be one cycle from sampled request to START/ACK high; START and ACK SHALL be high for exactly one cycle.
REQ-017 Selection SHALL be round-robin: search order begins at (last + 1) mod 3, wraps 2 -> 0, and picks the first asserted REQ bit; last <= sel on grant.
REQ-018 While SPI_BUSY = 1 in IDLE, no grant SHALL occur and pending REQ bits SHALL be held off without loss.
REQ-019 In WAIT, timer SHALL increment by 1 per cycle (8-bit, saturating).
- REQ is ignored in WAIT.
- DATA and GRANT_ID hold their values.
REQ-020 SPI_DONE = 1 in WAIT SHALL pulse TX_OK for one cycle and return the block to IDLE on the same edge.
REQ-021 In WAIT, when timer = TIMEOUT_CYC-1 and SPI_DONE = 0, the block SHALL pulse TX_ERR for one cycle and return to IDLE.
REQ-022 If SPI_DONE and the timeout condition coincide, SPI_DONE SHALL win: TX_OK = 1, TX_ERR = 0.
REQ-023 SPI_DONE received in IDLE SHALL be ignored (no pulse, no state change).
REQ-024 Return to IDLE SHALL always take at least one IDLE cycle before the next grant, so two START pulses are separated by at least 2 cycles.
REQ-025 Requesters drop REQ[i] no later than the cycle after ACK[i]; the arbiter SHALL NOT issue a second ACK for one REQ assertion, because the arbiter is in WAIT during that cycle.
REQ-026 DATA and GRANT_ID SHALL hold their last granted values in IDLE.

Reset
REQ-027 RESET high SHALL immediately force the following, regardless of clock:
- state IDLE
- DATA = 8'h00, START = 0, ACK = 3'b000, GRANT_ID = 0
- TX_OK = 0, TX_ERR = 0, timer = 0
- last = 2, so requester 0 has first priority.
REQ-028 RESET asserted mid-WAIT SHALL abandon the transfer with no TX_OK/TX_ERR pulse.
- After release, the first grant SHALL obey REQ-015 and REQ-017.
REQ-029 The first grant SHALL occur no earlier than the first rising edge after RESET deasserts.

Verification
REQ-030 Single request:
- Stimulus: REQ=001, DATA0=8'hA5, SPI_BUSY=0.
- Next edge: START=1, ACK=001, DATA=A5, GRANT_ID=0.
- SPI_DONE 5 cycles later -> TX_OK one cycle, state IDLE.
REQ-031 Round-robin fairness:
- Stimulus: REQ=111 held continuously, SPI_DONE returned 3 cycles after each START.
- Grant sequence SHALL be 0,1,2,0,1,2.
REQ-032 Timeout:
- Stimulus: TIMEOUT_CYC=16, grant requester 1, never pulse SPI_DONE.
- TX_ERR SHALL pulse exactly 16 cycles after START, with no TX_OK.
- Next REQ=010 SHALL be granted normally.
REQ-033 Busy hold-off:
- Stimulus: SPI_BUSY=1 for 10 cycles with REQ=100.
- No START during those cycles; START one edge after SPI_BUSY falls.
REQ-034 Coincidence: SPI_DONE asserted on the timeout cycle -> TX_OK=1, TX_ERR=0.
REQ-035 Reset mid-WAIT:
- Stimulus: RESET pulsed 2 cycles after START.
- All outputs zero immediately, no TX_OK/TX_ERR.
- With REQ=110 after release, requester 1 SHALL be granted first.

Source files
------------

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter
// Round-robin arbiter that hands one byte at a time from three requesters
// to a single SPI master. A grant launches the byte with a START pulse. The
// block then waits for SPI_DONE, or gives up after TIMEOUT_CYC cycles.
module spi_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       CLK_1KHZ,
  input  logic       RESET,
  input  logic [2:0] REQ,
  input  logic [7:0] DATA0,
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  output logic [2:0] ACK,
  input  logic       SPI_BUSY,
  input  logic       SPI_DONE,
  output logic [7:0] DATA,
  output logic       START,
  output logic [1:0] GRANT_ID,
  output logic       TX_OK,
  output logic       TX_ERR
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Timer value on which a transfer that is still waiting is aborted.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     r_state;
  logic [7:0] r_timer;
  logic [1:0] r_last;
  logic [7:0] r_data;
  logic [1:0] r_grant_id;
  logic       r_start;
  logic [2:0] r_ack;
  logic       r_tx_ok;
  logic       r_tx_err;

  logic [3:0] w_req4;
  logic [1:0] w_cand0;
  logic [1:0] w_cand1;
  logic [1:0] w_cand2;
  logic [1:0] w_sel;
  logic       w_any;
  logic [7:0] w_sel_data;

  // Next index in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // The request vector is padded to four bits so that any 2-bit index is in range.
  assign w_req4  = {1'b0, REQ};
  assign w_cand0 = rr_next(r_last);
  assign w_cand1 = rr_next(w_cand0);
  assign w_cand2 = rr_next(w_cand1);
  assign w_any   = |REQ;

  // Round-robin pick: the first asserted request after the last winner.
  always_comb begin
    // NOTE: every signal gets a default first, so a path that assigns nothing cannot infer a latch.
    w_sel = w_cand2;
    if (w_req4[w_cand1]) w_sel = w_cand1;
    if (w_req4[w_cand0]) w_sel = w_cand0;
  end

  // Byte offered by the selected requester.
  always_comb begin
    w_sel_data = DATA2;
    case (w_sel)
      2'd0:    w_sel_data = DATA0;
      2'd1:    w_sel_data = DATA1;
      default: w_sel_data = DATA2;
    endcase
  end

  // Grant / wait state machine. All outputs are registered.
  // NOTE: this block holds state, so it uses non-blocking assignments only. Each register then sees the values from before the edge.
  always_ff @(posedge CLK_1KHZ or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_timer    <= 8'd0;
      r_last     <= 2'd2;
      r_data     <= 8'h00;
      r_grant_id <= 2'd0;
      r_start    <= 1'b0;
      r_ack      <= 3'b000;
      r_tx_ok    <= 1'b0;
      r_tx_err   <= 1'b0;
    end else begin
      // Pulse outputs fall back to zero unless this edge raises them.
      r_start  <= 1'b0;
      r_ack    <= 3'b000;
      r_tx_ok  <= 1'b0;
      r_tx_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // SPI_DONE is ignored here. Requests wait while the master is busy.
          if (w_any && !SPI_BUSY) begin
            r_state    <= ST_WAIT;
            r_data     <= w_sel_data;
            r_grant_id <= w_sel;
            r_last     <= w_sel;
            r_start    <= 1'b1;
            r_ack      <= 3'b001 << w_sel;
            r_timer    <= 8'd0;
          end
        end

        ST_WAIT: begin
          // Completion has priority over a timeout on the same edge.
          if (SPI_DONE) begin
            r_tx_ok <= 1'b1;
            r_state <= ST_IDLE;
          end else if (r_timer == TIMEOUT_LAST) begin
            r_tx_err <= 1'b1;
            r_state  <= ST_IDLE;
          end else if (r_timer != 8'hFF) begin
            r_timer <= r_timer + 8'd1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DATA     = r_data;
  assign GRANT_ID = r_grant_id;
  assign START    = r_start;
  assign ACK      = r_ack;
  assign TX_OK    = r_tx_ok;
  assign TX_ERR   = r_tx_err;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter
// Directed bench for spi_tx_arbiter. A table of per-cycle vectors covers
// basic grants, round-robin rotation and busy hold-off. Hand-written
// sequences cover timeout, DONE/timeout coincidence and reset during WAIT.
module tb_spi_tx_arbiter;

  logic       CLK_1KHZ;
  logic       RESET;
  logic [2:0] REQ;
  logic [7:0] DATA0;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [2:0] ACK;
  logic       SPI_BUSY;
  logic       SPI_DONE;
  logic [7:0] DATA;
  logic       START;
  logic [1:0] GRANT_ID;
  logic       TX_OK;
  logic       TX_ERR;

  int n_checks = 0;
  int n_errors = 0;

  spi_tx_arbiter #(.TIMEOUT_CYC(16)) dut (
    .CLK_1KHZ (CLK_1KHZ),
    .RESET    (RESET),
    .REQ      (REQ),
    .DATA0    (DATA0),
    .DATA1    (DATA1),
    .DATA2    (DATA2),
    .ACK      (ACK),
    .SPI_BUSY (SPI_BUSY),
    .SPI_DONE (SPI_DONE),
    .DATA     (DATA),
    .START    (START),
    .GRANT_ID (GRANT_ID),
    .TX_OK    (TX_OK),
    .TX_ERR   (TX_ERR)
  );

  initial CLK_1KHZ = 1'b0;
  always #5 CLK_1KHZ = ~CLK_1KHZ;

  typedef struct {
    logic [2:0] req;
    logic       busy;
    logic       done;
    logic       start;
    logic [2:0] ack;
    logic [7:0] data;
    logic [1:0] gid;
    logic       ok;
    logic       err;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge CLK_1KHZ);
    #1;
  endtask

  task automatic check_all(input string tag, input logic start, input logic [2:0] ack,
                           input logic [7:0] data, input logic [1:0] gid,
                           input logic ok, input logic err);
    check({tag, " START"},    32'(START),    32'(start));
    check({tag, " ACK"},      32'(ACK),      32'(ack));
    check({tag, " DATA"},     32'(DATA),     32'(data));
    check({tag, " GRANT_ID"}, 32'(GRANT_ID), 32'(gid));
    check({tag, " TX_OK"},    32'(TX_OK),    32'(ok));
    check({tag, " TX_ERR"},   32'(TX_ERR),   32'(err));
  endtask

  initial begin
    int seen_start;
    int seen_bad;

    //           req     busy  done  start ack     data   gid   ok    err
    vecs[0]  = '{3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 1'b0, 1'b0, 1'b1, 3'b001, 8'hA5, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 8'hA5, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 8'hA5, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 8'hA5, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 8'hA5, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 8'hA5, 2'd0, 1'b1, 1'b0};
    vecs[7]  = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 8'hA5, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{3'b111, 1'b0, 1'b0, 1'b1, 3'b010, 8'h3C, 2'd1, 1'b0, 1'b0};
    vecs[9]  = '{3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 8'h3C, 2'd1, 1'b0, 1'b0};
    vecs[10] = '{3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 8'h3C, 2'd1, 1'b0, 1'b0};
    vecs[11] = '{3'b111, 1'b0, 1'b1, 1'b0, 3'b000, 8'h3C, 2'd1, 1'b1, 1'b0};
    vecs[12] = '{3'b111, 1'b0, 1'b0, 1'b1, 3'b100, 8'hC3, 2'd2, 1'b0, 1'b0};
    vecs[13] = '{3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 8'hC3, 2'd2, 1'b0, 1'b0};
    vecs[14] = '{3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 8'hC3, 2'd2, 1'b0, 1'b0};
    vecs[15] = '{3'b111, 1'b0, 1'b1, 1'b0, 3'b000, 8'hC3, 2'd2, 1'b1, 1'b0};
    vecs[16] = '{3'b111, 1'b0, 1'b0, 1'b1, 3'b001, 8'hA5, 2'd0, 1'b0, 1'b0};
    vecs[17] = '{3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 8'hA5, 2'd0, 1'b0, 1'b0};
    vecs[18] = '{3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 8'hA5, 2'd0, 1'b0, 1'b0};
    vecs[19] = '{3'b111, 1'b0, 1'b1, 1'b0, 3'b000, 8'hA5, 2'd0, 1'b1, 1'b0};
    vecs[20] = '{3'b111, 1'b0, 1'b0, 1'b1, 3'b010, 8'h3C, 2'd1, 1'b0, 1'b0};
    vecs[21] = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 8'h3C, 2'd1, 1'b1, 1'b0};
    vecs[22] = '{3'b100, 1'b1, 1'b0, 1'b0, 3'b000, 8'h3C, 2'd1, 1'b0, 1'b0};
    vecs[23] = '{3'b100, 1'b1, 1'b0, 1'b0, 3'b000, 8'h3C, 2'd1, 1'b0, 1'b0};
    vecs[24] = '{3'b100, 1'b0, 1'b0, 1'b1, 3'b100, 8'hC3, 2'd2, 1'b0, 1'b0};
    vecs[25] = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 8'hC3, 2'd2, 1'b1, 1'b0};

    RESET    = 1'b1;
    REQ      = 3'b000;
    DATA0    = 8'hA5;
    DATA1    = 8'h3C;
    DATA2    = 8'hC3;
    SPI_BUSY = 1'b0;
    SPI_DONE = 1'b0;

    // Reset state, sampled before any clock edge.
    #1;
    check_all("reset", 1'b0, 3'b000, 8'h00, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    RESET = 1'b0;

    // Table vectors: apply inputs, take one edge, compare the registered outputs.
    for (int i = 0; i < 26; i++) begin
      REQ      = vecs[i].req;
      SPI_BUSY = vecs[i].busy;
      SPI_DONE = vecs[i].done;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].start, vecs[i].ack, vecs[i].data,
                vecs[i].gid, vecs[i].ok, vecs[i].err);
    end
    REQ      = 3'b000;
    SPI_DONE = 1'b0;

    // Busy hold-off for 10 cycles, then a grant one edge after BUSY falls.
    REQ        = 3'b100;
    SPI_BUSY   = 1'b1;
    seen_start = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (START) seen_start++;
    end
    check("busy no START", 32'(seen_start), 32'd0);
    SPI_BUSY = 1'b0;
    tick();
    check_all("busy release", 1'b1, 3'b100, 8'hC3, 2'd2, 1'b0, 1'b0);
    REQ      = 3'b000;
    SPI_DONE = 1'b1;
    tick();
    check("busy done TX_OK", 32'(TX_OK), 32'd1);
    SPI_DONE = 1'b0;

    // Timeout: grant requester 1 and never send DONE. TX_ERR is due 16 cycles after START.
    REQ = 3'b010;
    tick();
    check_all("to grant", 1'b1, 3'b010, 8'h3C, 2'd1, 1'b0, 1'b0);
    REQ      = 3'b000;
    seen_bad = 0;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (TX_ERR || TX_OK || START) seen_bad++;
    end
    check("to early pulse", 32'(seen_bad), 32'd0);
    tick();
    check("to TX_ERR", 32'(TX_ERR), 32'd1);
    check("to TX_OK", 32'(TX_OK), 32'd0);
    tick();
    check("to TX_ERR one cycle", 32'(TX_ERR), 32'd0);

    // The next request is granted normally.
    REQ = 3'b010;
    tick();
    check_all("post-to grant", 1'b1, 3'b010, 8'h3C, 2'd1, 1'b0, 1'b0);
    REQ = 3'b000;

    // DONE on the timeout edge: completion wins over the timeout.
    for (int k = 1; k < 16; k++) tick();
    SPI_DONE = 1'b1;
    tick();
    check("coinc TX_OK", 32'(TX_OK), 32'd1);
    check("coinc TX_ERR", 32'(TX_ERR), 32'd0);
    SPI_DONE = 1'b0;

    // Reset in WAIT. Without the reset, last=1 would give requester 2 the next turn.
    REQ = 3'b010;
    tick();
    check_all("rst grant", 1'b1, 3'b010, 8'h3C, 2'd1, 1'b0, 1'b0);
    REQ = 3'b000;
    tick();
    tick();
    #2;
    RESET    = 1'b1;
    SPI_DONE = 1'b1;
    #1;
    check_all("rst async", 1'b0, 3'b000, 8'h00, 2'd0, 1'b0, 1'b0);
    tick();
    check_all("rst held", 1'b0, 3'b000, 8'h00, 2'd0, 1'b0, 1'b0);
    RESET    = 1'b0;
    SPI_DONE = 1'b0;
    REQ      = 3'b110;
    tick();
    check_all("rst regrant", 1'b1, 3'b010, 8'h3C, 2'd1, 1'b0, 1'b0);
    REQ = 3'b000;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
